// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: multicycle control FSM between the combinational
// instruction decoder and the shared datapath. It turns the decoder's
// per-instruction control bits into per-stage strobes: IR latch, PC advance,
// register-file write and data-memory request/write. It also handles syscall
// halt/resume and counts retired instructions.
//
// Optional feature macro: MC_DM_WAIT_EN
//   When defined, a dm_ready port is added and MEM holds until dm_ready=1.
//   When undefined, MEM always lasts exactly one cycle.
module multicycle_sequencer #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 is_jump,
  input  logic                 is_branch,
  input  logic                 w_en_regfile,
  input  logic                 w_en_datamem,
  input  logic                 is_load,
  input  logic                 syscall_en,
  input  logic                 syscall_halt,
  input  logic                 resume,
`ifdef MC_DM_WAIT_EN
  input  logic                 dm_ready,
`endif
  output logic                 ir_en,
  output logic                 pc_en,
  output logic                 rf_we,
  output logic                 dm_req,
  output logic                 dm_we,
  output logic                 halted,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  // Bit positions inside the latched decoder control vector.
  localparam int C_JUMP   = 5;
  localparam int C_BRANCH = 4;
  localparam int C_WRF    = 3;
  localparam int C_WDM    = 2;
  localparam int C_LOAD   = 1;
  localparam int C_SYS    = 0;

  state_e               state_q, state_d;
  logic [5:0]           ctrl_q, ctrl_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  logic                 mem_done_s;

`ifdef MC_DM_WAIT_EN
  assign mem_done_s = dm_ready;
`else
  assign mem_done_s = 1'b1;
`endif

  // While reset is asserted the visible state and count read as cleared,
  // even in the very first reset cycle before the registers have updated.
  assign state   = rst ? 3'd0 : state_q;
  assign retired = rst ? '0 : retired_q;

  // Next-state and Moore strobe decode; strobes are gated off during reset so
  // an aborted instruction never writes or retires.
  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    ir_en     = 1'b0;
    pc_en     = 1'b0;
    rf_we     = 1'b0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    halted    = 1'b0;
    if (rst) begin
      state_d = S_FETCH;
      ctrl_d  = 6'd0;
    end else begin
      case (state_q)
        S_FETCH: begin
          ir_en   = 1'b1;
          state_d = S_DECODE;
        end
        S_DECODE: begin
          ctrl_d  = {is_jump, is_branch, w_en_regfile, w_en_datamem, is_load, syscall_en};
          state_d = S_EXEC;
        end
        S_EXEC: begin
          if (ctrl_q[C_SYS] && syscall_halt) begin
            state_d = S_HALT;
          end else if (ctrl_q[C_SYS]) begin
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end else if ((ctrl_q[C_JUMP] || ctrl_q[C_BRANCH]) && !ctrl_q[C_WRF]) begin
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end else if (ctrl_q[C_LOAD] || ctrl_q[C_WDM]) begin
            state_d = S_MEM;
          end else begin
            state_d = S_WB;
          end
        end
        S_MEM: begin
          dm_req = 1'b1;
          dm_we  = ctrl_q[C_WDM];
          if (mem_done_s) begin
            if (ctrl_q[C_WDM]) begin
              pc_en   = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end else begin
            state_d = S_MEM;
          end
        end
        S_WB: begin
          rf_we   = ctrl_q[C_WRF];
          pc_en   = 1'b1;
          state_d = S_FETCH;
        end
        S_HALT: begin
          halted = 1'b1;
          if (resume) begin
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_HALT;
          end
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
    retired_d = retired_q + CNT_WIDTH'(pc_en);
  end

  // State, latched decoder controls and retired counter with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      ctrl_q    <= 6'd0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      retired_q <= retired_d;
    end
  end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

- Multicycle control FSM between the combinational instruction decoder and the shared datapath (IR, PC, register file, data memory).
- Takes the decoder's per-instruction control bits and turns them into per-stage strobes: IR latch, PC advance, register-file write, data-memory request/write.
- Handles syscall halt/resume and counts retired instructions.
- Lets the core run multicycle without changing the decoder.

## Interface
Parameters:
- CNT_WIDTH, 32, width of the retired-instruction counter

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- is_jump  in  1  decoder: jump instruction (j, jal, jr)
- is_branch  in  1  decoder: conditional branch
- w_en_regfile  in  1  decoder: instruction writes register file
- w_en_datamem  in  1  decoder: store instruction
- is_load  in  1  decoder: load instruction (regfile data from DM)
- syscall_en  in  1  decoder: syscall instruction
- syscall_halt  in  1  syscall handler: current syscall requests halt
- resume  in  1  leave HALT; ignored in every other state
- dm_ready  in  1  data-memory access complete; present only with MC_DM_WAIT_EN
- ir_en  out  1  latch instruction register
- pc_en  out  1  commit next PC; one pulse per retired instruction
- rf_we  out  1  register-file write strobe
- dm_req  out  1  data-memory access request
- dm_we  out  1  data-memory write strobe
- halted  out  1  sequencer in HALT
- state  out  3  current state encoding
- retired  out  CNT_WIDTH  retired-instruction count

## Operation
- State encodings:
  - FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6 and 7 go to FETCH on the next edge.
- Outputs are Moore-decoded from the state register, gated by the latched decoder inputs.
- Decoder inputs must be stable from DECODE until the instruction retires.
- FETCH: ir_en=1 -> DECODE.
- DECODE: no strobes -> EXEC.
- EXEC, checked in priority order:
  - syscall_en && syscall_halt -> HALT, no pc_en.
  - syscall_en -> pc_en=1 -> FETCH.
  - (is_jump || is_branch) && !w_en_regfile -> pc_en=1 -> FETCH.
  - is_load || w_en_datamem -> MEM.
  - otherwise -> WB (ALU ops, jal).
- MEM:
  - dm_req=1; dm_we=w_en_datamem.
  - Store: pc_en=1 -> FETCH.
  - Load: -> WB.
- WB: rf_we=w_en_regfile, pc_en=1 -> FETCH.
- HALT: halted=1, all strobes 0. resume=1 -> pc_en=1 -> FETCH, which advances past the syscall.
- retired: increments by 1 on every cycle with pc_en=1; wraps modulo 2^CNT_WIDTH.
- Only one of rf_we, dm_we and ir_en is ever high in a given cycle.

## Timing
- Reset:
  - While rst=1: state=FETCH, retired=0, and ir_en, pc_en, rf_we, dm_req, dm_we, halted are all 0.
  - First cycle after release: FETCH with ir_en=1.
- Reset mid-instruction aborts it: no rf_we/dm_we/pc_en in the reset cycle, and retired is not incremented.
- Cycles per instruction (FETCH to pc_en inclusive, no wait states):
  - branch, j, jr, non-halt syscall: 3
  - store, ALU, jal: 4
  - load: 5
- Resume from HALT: pc_en in the same cycle resume is sampled; FETCH on the next cycle.
- resume held high outside HALT has no effect. resume held across HALT entry exits on the first HALT cycle it is sampled high.

## Configuration
- MC_DM_WAIT_EN
  - Defined:
    - dm_ready port exists.
    - MEM holds (dm_req=1, dm_we=w_en_datamem held) until dm_ready=1.
    - Transition and pc_en (store) occur in the dm_ready cycle.
    - rst during a wait aborts the access.
  - Undefined:
    - No dm_ready port.
    - MEM always lasts exactly one cycle.

## Test plan
- rst held 3 cycles, then released:
  - state=0, all strobes 0 during reset.
  - ir_en=1 on the first cycle after release.
  - retired=0.
- lw (is_load=1, w_en_regfile=1):
  - States 0,1,2,3,4.
  - dm_req in cycle 4; rf_we and pc_en in cycle 5.
  - retired 0->1.
- Sequence beq, sw, addu, jal:
  - Retire cycles 3, 4, 4, 4; retired=4 after 15 cycles.
  - dm_we only in sw MEM; rf_we only in addu and jal WB.
- syscall with syscall_halt=1:
  - Enters HALT at cycle 3; halted=1, retired unchanged for 10 cycles.
  - resume pulse -> pc_en=1, retired+1, FETCH next cycle.
- With MC_DM_WAIT_EN, sw with dm_ready low 4 cycles:
  - dm_we high 5 cycles; pc_en only in the dm_ready cycle.
  - rst asserted in wait cycle 2 -> dm_we=0 and state=0 on the following cycle.
- retired preloaded near wrap (CNT_WIDTH=4, 15 retirements then 1 more) -> retired reads 15, then 0.
